dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding load/store, word or byte, fixed response delay.
// Latency: resp_valid rises LATENCY cycles after the accepting edge; resp_rdata is registered.
// Backpressure: req_ready is low from acceptance through the response cycle; the response cannot be stalled.
//
// Ports:
//   clock, reset_n           single clock, synchronous active-low reset
//   req_valid / req_ready    request handshake; req_write (1=store), req_byte (1=byte access),
//                            req_addr (byte address), req_wdata (store data, [7:0] for byte stores)
//   resp_valid / resp_rdata  one-cycle completion pulse with load data (zero for stores)
//   busy                     high while a request is outstanding (pipeline stall)
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        busy
);

    localparam int AW = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic              r_req_write;
    logic              r_req_byte;
    logic [AW-1:0]     r_req_addr;
    logic [31:0]       r_req_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [2**DEPTH_LOG2];

    logic              w_accept;
    logic              w_go_resp;
    logic              w_op_write;
    logic              w_op_byte;
    logic [AW-1:0]     w_op_addr;
    logic [31:0]       w_op_wdata;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [4:0]        w_lane_lsb;
    logic [31:0]       w_old;
    logic [7:0]        w_old_byte;
    logic [31:0]       w_merged;
    logic [31:0]       w_load_data;
    logic              w_unused_addr_bits;

    // Upper address bits are deliberately dropped so accesses wrap modulo the depth.
    assign w_unused_addr_bits = ^req_addr[31:AW];

    assign w_accept = req_valid && req_ready;

    // FSM next state and outputs. Outputs are forced low while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        w_go_resp    = 1'b0;
        req_ready    = 1'b0;
        busy         = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // Memory commit and load sampling happen on the edge that enters RESP.
        w_go_resp  = (w_next_state == ST_RESP) && (r_state != ST_RESP);
        req_ready  = reset_n && (r_state == ST_IDLE);
        busy       = reset_n && (r_state != ST_IDLE);
        resp_valid = reset_n && (r_state == ST_RESP);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_cnt <= 4'(LATENCY - 1);
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture; only meaningful while WAIT is pending.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_req_write <= req_write;
            r_req_byte  <= req_byte;
            r_req_addr  <= req_addr[AW-1:0];
            r_req_wdata <= req_wdata;
        end
    end

    // With LATENCY=1 the RESP edge is the accepting edge, so use the live request there.
    assign w_op_write = (r_state == ST_IDLE) ? req_write         : r_req_write;
    assign w_op_byte  = (r_state == ST_IDLE) ? req_byte          : r_req_byte;
    assign w_op_addr  = (r_state == ST_IDLE) ? req_addr[AW-1:0]  : r_req_addr;
    assign w_op_wdata = (r_state == ST_IDLE) ? req_wdata         : r_req_wdata;

    assign w_idx      = w_op_addr[AW-1:2];
    assign w_lane_lsb = {w_op_addr[1:0], 3'b000};
    assign w_old      = r_mem[w_idx];
    assign w_old_byte = w_old[w_lane_lsb +: 8];

    // Byte store: read the word, replace one lane, write the whole word back.
    always_comb begin
        w_merged = w_old;
        w_merged[w_lane_lsb +: 8] = w_op_wdata[7:0];
    end

    assign w_load_data = w_op_byte ? {{24{w_old_byte[7]}}, w_old_byte} : w_old;

    // Array contents survive reset; a reset edge suppresses a pending commit.
    always_ff @(posedge clock) begin
        if (reset_n && w_go_resp && w_op_write) begin
            r_mem[w_idx] <= w_op_byte ? w_merged : w_op_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rdata <= 32'h0;
        end else if (w_go_resp) begin
            r_rdata <= w_op_write ? 32'h0 : w_load_data;
        end
    end

    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/reset, LATENCY=1 instance for back-to-back.
// Latency: n/a (testbench).
// Backpressure: requests wait for req_ready, all waits are cycle-bounded.
module tb_dmem_responder;

    logic        clk;
    logic        reset_n;

    logic        req_valid, req_ready, req_write, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, busy;
    logic [31:0] resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_byte;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_busy;
    logic [31:0] b_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
        .clock(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_byte(b_req_byte), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 instance. lat counts cycles from the
    // accepting cycle to the resp_valid cycle; bsy counts cycles with busy high.
    task automatic req2(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int bsy);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        lat = 1;
        bsy = 0;
        while (!resp_valid && lat < 20) begin
            if (busy) bsy++;
            @(negedge clk);
            lat++;
        end
        if (busy) bsy++;
        rd = resp_rdata;
    endtask

    // Store/load on the LATENCY=1 instance, used only to seed its array.
    task automatic req1_store(input logic [31:0] a, input logic [31:0] d);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!b_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_byte = 1'b0; b_req_addr = a; b_req_wdata = d;
        @(negedge clk);
        b_req_valid = 1'b0; b_req_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, bsy, seen, guard;

        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_byte = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        // Word round trip
        req2(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, lat, bsy);
        chk("sw_lat", lat, 2);
        chk("sw_busy_cycles", bsy, 2);
        chk("sw_rdata_zero", rd, 32'h0);
        @(negedge clk);
        chk("resp_one_cycle", {31'b0, resp_valid}, 32'h0);
        chk("ready_after_resp", {31'b0, req_ready}, 32'h1);
        chk("rdata_held", resp_rdata, 32'h0);
        req2(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, bsy);
        chk("lw_lat", lat, 2);
        chk("lw_busy_cycles", bsy, 2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        @(negedge clk);
        chk("lw_rdata_held", resp_rdata, 32'hDEADBEEF);

        // Byte merge and sign extension
        req2(1'b1, 1'b0, 32'h20, 32'h11223344, rd, lat, bsy);
        req2(1'b1, 1'b1, 32'h22, 32'h000000AB, rd, lat, bsy);
        chk("sb_rdata_zero", rd, 32'h0);
        req2(1'b0, 1'b0, 32'h20, 32'h0, rd, lat, bsy);
        chk("byte_merge", rd, 32'h11AB3344);
        req2(1'b0, 1'b1, 32'h22, 32'h0, rd, lat, bsy);
        chk("lb_neg", rd, 32'hFFFFFFAB);
        req2(1'b0, 1'b1, 32'h21, 32'h0, rd, lat, bsy);
        chk("lb_pos", rd, 32'h00000033);
        req2(1'b0, 1'b1, 32'h23, 32'h0, rd, lat, bsy);
        chk("lb_lane3", rd, 32'h00000011);
        req2(1'b0, 1'b1, 32'h20, 32'h0, rd, lat, bsy);
        chk("lb_lane0", rd, 32'h00000044);
        // Byte store ignores upper data bits
        req2(1'b1, 1'b1, 32'h20, 32'hFFFFFF99, rd, lat, bsy);
        req2(1'b0, 1'b0, 32'h20, 32'h0, rd, lat, bsy);
        chk("sb_lane0_only", rd, 32'h11AB3399);

        // Wrap and alignment
        req2(1'b1, 1'b0, 32'h400, 32'h5A5A5A5A, rd, lat, bsy);
        req2(1'b0, 1'b0, 32'h003, 32'h0, rd, lat, bsy);
        chk("wrap_align", rd, 32'h5A5A5A5A);
        req2(1'b0, 1'b0, 32'hFFFF_F412, 32'h0, rd, lat, bsy);
        chk("wrap_upper_ignored", rd, 32'hDEADBEEF);

        // Reset during WAIT drops a pending store
        req2(1'b1, 1'b0, 32'h30, 32'h00000077, rd, lat, bsy);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h30; req_wdata = 32'h1;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        chk("wait_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_forces_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_forces_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        chk("wait_rst_no_resp", seen, 0);
        chk("wait_rst_rdata_clr", resp_rdata, 32'h0);
        req2(1'b0, 1'b0, 32'h30, 32'h0, rd, lat, bsy);
        chk("wait_rst_no_commit", rd, 32'h00000077);

        // Reset during RESP keeps the committed store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("resp_seen_before_rst", {31'b0, resp_valid}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req2(1'b0, 1'b0, 32'h40, 32'h0, rd, lat, bsy);
        chk("resp_rst_kept", rd, 32'hCAFEF00D);

        // Back-to-back loads on the LATENCY=1 instance
        for (int i = 0; i < 4; i++) begin
            req1_store(32'(4 * i), 32'h100 + 32'(i));
        end
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("b2b_ready_%0d", c), {31'b0, b_req_ready}, (c % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("b2b_resp_%0d", c), {31'b0, b_resp_valid}, (c % 2 == 1) ? 32'h1 : 32'h0);
            if (c % 2 == 1) begin
                chk($sformatf("b2b_rdata_%0d", c), b_resp_rdata, 32'h100 + 32'(c / 2));
                b_req_addr = 32'(4 * (c / 2 + 1));
            end
        end
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_after", {31'b0, b_busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
